// File: rtl/md_unit_param.sv
// md_unit_param: HI/LO multiply-divide unit with configurable multiply latency,
// iterative restoring radix-2 divider, divide-by-zero pulse and start/busy handshake.
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [3:0]       MDOp,
  input  logic             MDStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Out,
  output logic             MDBusy,
  output logic             DivZero
);

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dquo, drem, ddvs;
  logic               q_neg, r_neg;
  logic               div_zero;

  logic               op_mul, op_div, accept;
  logic               mul_signed, div_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0] ext_a, ext_b, product, hilo, mul_res;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, trial;

  // Decode, operand conditioning, product/accumulate and one divider step
  always_comb begin
    op_mul     = (MDOp >= 4'd1) && (MDOp <= 4'd6);
    op_div     = (MDOp == 4'd14) || (MDOp == 4'd15);
    accept     = (state == S_IDLE) && MDStart && (op_mul || op_div);

    mul_signed = MDOp[0];
    ext_a      = {{WIDTH{mul_signed & A[WIDTH-1]}}, A};
    ext_b      = {{WIDTH{mul_signed & B[WIDTH-1]}}, B};
    product    = ext_a * ext_b;
    hilo       = {hi, lo};
    case (MDOp)
      4'd3, 4'd4: mul_res = hilo + product;
      4'd5, 4'd6: mul_res = hilo - product;
      default:    mul_res = product;
    endcase

    div_signed = (MDOp == 4'd14);
    a_neg      = div_signed & A[WIDTH-1];
    b_neg      = div_signed & B[WIDTH-1];
    a_mag      = a_neg ? -A : A;
    b_mag      = b_neg ? -B : B;

    // Partial remainder stays below the divisor, so the trial's top bit is its sign
    shifted    = {drem, dquo[WIDTH-1]};
    trial      = shifted - {1'b0, ddvs};
  end

  // Control FSM, HI/LO registers and divider datapath
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      dquo     <= '0;
      drem     <= '0;
      ddvs     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && op_mul) begin
            acc   <= mul_res;
            cnt   <= CW'(MUL_LAT - 1);
            state <= S_MUL;
          end else if (accept && op_div) begin
            if (B == '0) begin
              div_zero <= 1'b1;
            end else begin
              dquo  <= a_mag;
              drem  <= '0;
              ddvs  <= b_mag;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              cnt   <= CW'(WIDTH - 1);
              state <= S_DIV;
            end
          end else if (MDOp == 4'd7) begin
            hi <= A;
          end else if (MDOp == 4'd8) begin
            lo <= A;
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= acc;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (!trial[WIDTH]) begin
            drem <= trial[WIDTH-1:0];
            dquo <= {dquo[WIDTH-2:0], 1'b1};
          end else begin
            drem <= shifted[WIDTH-1:0];
            dquo <= {dquo[WIDTH-2:0], 1'b0};
          end
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          lo    <= q_neg ? -dquo : dquo;
          hi    <= r_neg ? -drem : drem;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read port and status
  always_comb begin
    Out = '0;
    if (MDOp == 4'd9)       Out = hi;
    else if (MDOp == 4'd10) Out = lo;
    MDBusy  = (state != S_IDLE);
    DivZero = div_zero;
  end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised successor to the CPU's HI/LO multiply-divide unit. Sits beside the EX stage and is driven by the same 4-bit MDOp encoding.
- Replaces the single-cycle multiply/divide with a configurable-latency multiplier and a true iterative radix-2 divider.
- Adds width generalisation, a divide-by-zero indication, defined overflow results, and strict start/busy handshaking.

Parameters:
- WIDTH, 32, operand and HI/LO register width; must be at least 4.
- MUL_LAT, 5, cycles from accepted multiply start to HI/LO commit; must be at least 1.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- MDOp  input  4  operation: 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 MTHI, 8 MTLO, 9 MFHI, 10 MFLO, 14 DIV, 15 DIVU; other codes are no-op.
- MDStart  input  1  start strobe for codes 1-6 and 14-15.
- A  input  WIDTH  operand A, or the write data for MTHI/MTLO.
- B  input  WIDTH  operand B.
- Out  output  WIDTH  Hi when MDOp=9, Lo when MDOp=10, else 0 (combinational).
- MDBusy  output  1  an operation is in flight; the pipeline stalls on it.
- DivZero  output  1  one-cycle pulse when a divide start has B=0.

Behaviour:
- Reset (Rst_n=0 at an edge):
  - Hi=Lo=0, MDBusy=0, DivZero=0, FSM=IDLE.
  - Reset overrides everything, including an operation in flight; the partial result is discarded.
- FSM states: IDLE, MUL, DIV, FIX. MDBusy=1 in every state except IDLE.
- Accept rule: a start is accepted only when FSM=IDLE, MDStart=1 and MDOp is in 1-6 or 14-15.
  - MDStart while busy is ignored (no queueing).
  - MDStart with any other MDOp is ignored.
- MTHI/MTLO (7/8): write A to Hi/Lo at the edge, only in IDLE. Ignored while busy. They take effect regardless of MDStart.
- Multiply (1-6), accepted at edge N:
  - The full 2*WIDTH-bit product is computed from A and B as latched at N. Signed for 1/3/5; zero-extended for 2/4/6.
  - MADD/MSUB use {Hi,Lo} as it stands at edge N.
  - Sum/difference is modulo 2^(2*WIDTH).
  - FSM goes to MUL with a counter of MUL_LAT-1.
  - {Hi,Lo} is committed at edge N+MUL_LAT, and FSM returns to IDLE on that same edge.
  - MDBusy is high for exactly MUL_LAT cycles.
  - With MUL_LAT=1 the commit happens at N+1.
- Divide (14/15), accepted at edge N with B!=0:
  - At edge N, latch the absolute values (signed op) or raw values (unsigned op) and the result signs.
  - DIV state: one restoring shift-subtract step per cycle, WIDTH cycles.
  - FIX state: apply signs. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Commit Lo=quotient, Hi=remainder at edge N+WIDTH+1. MDBusy is high for WIDTH+1 cycles.
  - Signed overflow (A = most-negative value, B = -1): Lo = most-negative value, Hi = 0, normal latency.
- Divide with B=0 at accept:
  - No state change; Hi/Lo unchanged; MDBusy stays 0.
  - DivZero=1 for the cycle after the edge.
- Out is purely combinational from Hi/Lo. While busy it shows the pre-operation values.
- A start in the cycle following a commit is legal: back-to-back operations.

Test Plan:
- WIDTH=32, MUL_LAT=5: MULT A=FFFFFFFD, B=00000007 -> MDBusy high exactly 5 cycles, then Hi=FFFFFFFF, Lo=FFFFFFEB; MFLO returns FFFFFFEB.
- MULTU A=FFFFFFFF, B=2 -> Hi=00000001, Lo=FFFFFFFE. Then MADD A=1, B=2 -> Hi=00000002, Lo=00000000.
- DIV A=FFFFFFF9, B=2 -> after 33 busy cycles Lo=FFFFFFFD, Hi=FFFFFFFF. DIVU with the same operands -> Lo=7FFFFFFC, Hi=00000001.
- Divide edge cases:
  - DIV B=0 with Hi=Lo=0000_1234 -> DivZero single-cycle pulse, MDBusy never high, Hi/Lo unchanged.
  - DIV A=80000000, B=FFFFFFFF -> Lo=80000000, Hi=0.
- Mid-DIV interference:
  - MTHI A=5 and MDStart MULT issued mid-DIV -> both ignored; the divide result commits unchanged.
  - Rst_n=0 for one edge mid-DIV -> Hi=Lo=0, MDBusy=0 after that edge.
- WIDTH=8, MUL_LAT=1 instance:
  - MULTU FF*FF -> Hi=FE, Lo=01 one edge after accept.
  - DIVU 0xC8/0x07 -> Lo=1C, Hi=04 after 9 busy cycles.
